test_delay_arbiter: RTL
=======================

# test_delay_arbiter

Round-robin arbiter that shares one latency-insensitive val/rdy output channel among `p_num_reqs` test requesters. It forces a programmable idle gap after every transfer. It sits in unit-test harnesses between several test sources and a single random-delay stage or DUT port, and tags each message with its source index. Its job is to sequence access to the shared delayed channel deterministically, so that contention and back-pressure can be exercised from the command line.

## Interface
- `p_msg_nbits`, 1: message width in bits
- `p_num_reqs`, 4: number of requesters, at least 2
- `clk` input 1: single clock; all state updates on its rising edge
- `reset` input 1: synchronous, active-low (0 = reset)
- `gap` input 32: idle cycles forced after each transfer; sampled on the transfer cycle
- `in_val` input `p_num_reqs`: per-requester valid
- `in_rdy` output `p_num_reqs`: per-requester ready; one-hot or zero
- `in_msg` input `p_num_reqs*p_msg_nbits`: requester i occupies bits [i*p_msg_nbits +: p_msg_nbits]
- `out_val` output 1: output valid
- `out_rdy` input 1: output ready
- `out_msg` output `p_msg_nbits`: granted message
- `out_src` output clog2(`p_num_reqs`): index of the granted requester

## Operation
- **State:** 2-bit FSM with states IDLE, LOCK and GAP, plus:
  - `ptr`: round-robin priority pointer
  - `grant_q`: locked index
  - `gap_cnt`: 32-bit gap counter
- **Selection:** winner = first i with `in_val[i]=1`, scanning `ptr`, `ptr+1`, … modulo `p_num_reqs`.
- **IDLE:**
  - No request: `out_val=0`.
  - With requests: winner passes through combinationally. `out_val=1`, `out_msg`/`out_src` = winner, `in_rdy[winner]=out_rdy`.
  - On transfer: if `gap==0`, stay in IDLE; else go to GAP with `gap_cnt<=gap-1`.
  - If `out_rdy=0`: `grant_q<=winner`, go to LOCK.
- **LOCK:**
  - Only `grant_q` is connected; other requesters stall even if valid.
  - Transfer: same gap rule as IDLE.
  - `in_val[grant_q]` drops: protocol violation. Return to IDLE next cycle, no transfer, `ptr` unchanged.
- **GAP:**
  - `out_val=0`, `in_rdy=0`.
  - `gap_cnt>0`: decrement. `gap_cnt==0`: go to IDLE.
- **Pointer:** on every transfer, `ptr <= (granted+1) mod p_num_reqs`. Wrap uses explicit compare, not a power-of-2 mask.
- **Output idle values:** `out_msg` and `out_src` are 0 when `out_val=0`; no X on the outputs.
- **Reset:** state IDLE, `ptr=0`, `grant_q=0`, `gap_cnt=0`.
  - During reset, all outputs are 0.
  - Reset asserted mid-LOCK or mid-GAP aborts immediately; no transfer completes in that cycle.

## Timing
- Zero-cycle latency in IDLE: input-to-output is combinational when `out_rdy=1`.
- Throughput with `gap=0`: one message per cycle. With gap g: one message per g+1 cycles.
- A transfer is `out_val && out_rdy`, which is exactly `in_val[i] && in_rdy[i]` for the granted i.
- Once `out_val` is asserted in LOCK, `out_msg` and `out_src` are stable until transfer. IDLE→LOCK keeps the same winner.
- `gap` changes take effect only at the next transfer.
- Maximum gap is 2^32-1 cycles; no overflow because the counter only decrements.

## Structure
- Shared package `test_delay_arbiter_pkg`:
  - state enum (IDLE=0, LOCK=1, GAP=2)
  - `c_src_nbits` localparam function (clog2, minimum 1)
- One sub-module, `test_rr_pick`: combinational rotate-priority encoder with inputs `req`, `ptr` and outputs `grant_idx`, `any`.
- Registers use the existing enable/reset register components with active-low reset wiring.
- Line tracing uses the existing trace helpers: granted source, state, `gap_cnt`.

## Test plan
- **Basic pass-through:** N=4, `gap=0`, only req 2 valid with msg 0xA, `out_rdy=1`.
  - Same cycle: `out_val=1`, `out_msg=0xA`, `out_src=2`, `in_rdy=4'b0100`.
  - Next cycle: `ptr=3`.
- **Fairness:** all 4 always valid, `gap=0`, `out_rdy=1` for 8 cycles.
  - `out_src` sequence is 0,1,2,3,0,1,2,3.
- **Back-pressure lock:** reqs 1 and 3 valid, `out_rdy=0` for 3 cycles, then 1.
  - `out_src` stays 1 throughout; transfer on cycle 4.
  - `in_rdy[3]=0` the whole time; next grant is 3.
- **Gap:** `gap=2`, all valid.
  - Transfers occur on cycles 0, 3, 6.
  - `out_val=0` and `in_rdy=0` on cycles 1-2 and 4-5.
- **Violation and reset:**
  - LOCK on req 0, then drop `in_val[0]`: IDLE next cycle, `ptr` unchanged.
  - Separately, `reset=0` mid-GAP with `gap_cnt=5`: next cycle state IDLE, all outputs 0, `ptr=0`.

Source files
------------

// File: rtl/test_delay_arbiter_pkg.sv
// Shared state encoding and sizing helper for the delayed round-robin test arbiter.
package test_delay_arbiter_pkg;

   typedef logic [1:0] state_t;

   localparam state_t IDLE = 2'd0;
   localparam state_t LOCK = 2'd1;
   localparam state_t GAP  = 2'd2;

   // Source index width; a two-requester arbiter still needs one bit.
   function automatic int c_src_nbits(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/test_rr_pick.sv
// Rotate-priority encoder: first asserted req at or after ptr, wrapping modulo p_num_reqs.
module test_rr_pick
   import test_delay_arbiter_pkg::*;
#(
   parameter int p_num_reqs  = 4,
   parameter int p_src_nbits = c_src_nbits(p_num_reqs)
) (
   input  logic [p_num_reqs-1:0]  req,
   input  logic [p_src_nbits-1:0] ptr,
   output logic [p_src_nbits-1:0] grant_idx,
   output logic                   any
);

   logic [p_src_nbits:0]   sum;
   logic [p_src_nbits-1:0] idx;

   always_comb begin
      grant_idx = '0;
      any       = 1'b0;
      sum       = '0;
      idx       = '0;
      for (int k = 0; k < p_num_reqs; k++) begin
         // Explicit compare wrap so non-power-of-two requester counts work.
         sum = {1'b0, ptr} + (p_src_nbits + 1)'(k);
         if (sum >= (p_src_nbits + 1)'(p_num_reqs))
            sum = sum - (p_src_nbits + 1)'(p_num_reqs);
         idx = sum[p_src_nbits-1:0];
         if (!any && req[idx]) begin
            any       = 1'b1;
            grant_idx = idx;
         end
      end
   end

endmodule

// File: rtl/test_delay_arbiter.sv
// Round-robin share of one val/rdy channel with a programmable idle gap after each transfer.
// Zero-cycle pass-through when idle; a stalled winner is locked until it transfers or drops.
module test_delay_arbiter
   import test_delay_arbiter_pkg::*;
#(
   parameter int p_msg_nbits = 1,
   parameter int p_num_reqs  = 4
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic [31:0]                       gap,
   input  logic [p_num_reqs-1:0]             in_val,
   output logic [p_num_reqs-1:0]             in_rdy,
   input  logic [p_num_reqs*p_msg_nbits-1:0] in_msg,
   output logic                              out_val,
   input  logic                              out_rdy,
   output logic [p_msg_nbits-1:0]            out_msg,
   output logic [c_src_nbits(p_num_reqs)-1:0] out_src
);

   localparam int c_w = c_src_nbits(p_num_reqs);

   state_t         state;
   logic [c_w-1:0] ptr;
   logic [c_w-1:0] grant_q;
   logic [31:0]    gap_cnt;

   logic [c_w-1:0] win_idx;
   logic [c_w-1:0] sel_idx;
   logic [c_w-1:0] ptr_next;
   logic           any;
   logic           active;
   logic           xfer;

   test_rr_pick #(
      .p_num_reqs  (p_num_reqs),
      .p_src_nbits (c_w)
   ) u_pick (
      .req       (in_val),
      .ptr       (ptr),
      .grant_idx (win_idx),
      .any       (any)
   );

   always_comb begin
      sel_idx = (state == LOCK) ? grant_q : win_idx;
      active  = 1'b0;
      // Reset gates every output so nothing can transfer while it is held.
      if (reset) begin
         case (state)
            IDLE:    active = any;
            LOCK:    active = in_val[grant_q];
            default: active = 1'b0;
         endcase
      end

      out_val = active;
      out_src = active ? sel_idx : '0;
      out_msg = '0;
      in_rdy  = '0;
      if (active) begin
         out_msg         = in_msg[sel_idx*p_msg_nbits +: p_msg_nbits];
         in_rdy[sel_idx] = out_rdy;
      end

      xfer     = active && out_rdy;
      ptr_next = (sel_idx == c_w'(p_num_reqs - 1)) ? '0 : sel_idx + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state   <= IDLE;
         ptr     <= '0;
         grant_q <= '0;
         gap_cnt <= '0;
      end else begin
         case (state)
            IDLE, LOCK: begin
               if (xfer) begin
                  ptr <= ptr_next;
                  if (gap != 32'd0) begin
                     state   <= GAP;
                     gap_cnt <= gap - 32'd1;
                  end else begin
                     state <= IDLE;
                  end
               end else if (active) begin
                  grant_q <= sel_idx;
                  state   <= LOCK;
               end else begin
                  // No request, or the locked source withdrew: re-arbitrate.
                  state <= IDLE;
               end
            end
            GAP: begin
               if (gap_cnt == 32'd0)
                  state <= IDLE;
               else
                  gap_cnt <= gap_cnt - 32'd1;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
